// File: rtl/llsc_arbiter_pkg.sv
// Shared types for the LL/SC arbiter: memory instruction kinds, FSM states
// and the response-success helper.
package llsc_arbiter_pkg;

  typedef enum logic [2:0] {
    NO_MEM_INST   = 3'd0,
    IS_LD_INST    = 3'd1,
    IS_ST_INST    = 3'd2,
    IS_LDL_INST   = 3'd3,
    IS_STQ_INST   = 3'd4,
    IS_STQ_C_INST = 3'd5
  } MEM_INST_TYPE;

  // Number of reservation-table entries on the far side of the arbiter.
  localparam int unsigned LLSC_SIZE = 4;

  typedef enum logic {
    StRun,
    StStall
  } llsc_state_e;

  function automatic logic is_llsc_inst(input MEM_INST_TYPE t);
    return (t == IS_LDL_INST) || (t == IS_STQ_INST) || (t == IS_STQ_C_INST);
  endfunction

  function automatic logic resp_success(input MEM_INST_TYPE t, input logic store_ok);
    logic ok;
    ok = 1'b0;
    unique case (t)
      IS_STQ_C_INST: ok = store_ok;
      IS_STQ_INST:   ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/llsc_req_fifo.sv
// In-order request queue with two write ports and two read ports.
// Port 1 writes ahead of port 2; reads pop 0, 1 or 2 entries from the head.
module llsc_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr1_en_i,
  input  logic [Width-1:0] wr1_data_i,
  input  logic             wr2_en_i,
  input  logic [Width-1:0] wr2_data_i,
  input  logic [1:0]       rd_cnt_i,
  output logic             rd0_valid_o,
  output logic [Width-1:0] rd0_data_o,
  output logic             rd1_valid_o,
  output logic [Width-1:0] rd1_data_o,
  output logic [CntW-1:0]  free_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0]  wr2_idx, head1_idx;
  logic [CntW-1:0]  count_q, count_d;
  logic [1:0]       wr_cnt;

  always_comb begin
    wr_cnt    = 2'(wr1_en_i) + 2'(wr2_en_i);
    // A lone port-2 write lands in the first free slot.
    wr2_idx   = wr1_en_i ? tail_q + PtrW'(1) : tail_q;
    head1_idx = head_q + PtrW'(1);
    head_d    = head_q + PtrW'(rd_cnt_i);
    tail_d    = tail_q + PtrW'(wr_cnt);
    count_d   = count_q + CntW'(wr_cnt) - CntW'(rd_cnt_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!flush_i) begin
        if (wr1_en_i) mem_q[tail_q] <= wr1_data_i;
        if (wr2_en_i) mem_q[wr2_idx] <= wr2_data_i;
      end
    end
  end

  assign rd0_valid_o = (count_q != '0);
  assign rd1_valid_o = (count_q >= CntW'(2));
  assign rd0_data_o  = mem_q[head_q];
  assign rd1_data_o  = mem_q[head1_idx];
  assign free_o      = CntW'(Depth) - count_q;

endmodule

// File: rtl/llsc_arbiter.sv
// Arbitrates LL/SC requests from two ports into the reservation table:
// queues them, issues up to two in order per cycle and registers responses.
module llsc_arbiter
  import llsc_arbiter_pkg::*;
#(
  parameter int unsigned Q_DEPTH     = 4,
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req1_valid_i,
  input  MEM_INST_TYPE      req1_type_i,
  input  logic [63:0]       req1_addr_i,
  input  logic [TAG_W-1:0]  req1_tag_i,
  output logic              req1_ready_o,
  input  logic              req2_valid_i,
  input  MEM_INST_TYPE      req2_type_i,
  input  logic [63:0]       req2_addr_i,
  input  logic [TAG_W-1:0]  req2_tag_i,
  output logic              req2_ready_o,
  output MEM_INST_TYPE      llsc_inst1_type_o,
  output logic [63:0]       llsc_inst1_addr_o,
  input  logic              llsc_inst1_store_success_i,
  output MEM_INST_TYPE      llsc_inst2_type_o,
  output logic [63:0]       llsc_inst2_addr_o,
  input  logic              llsc_inst2_store_success_i,
  input  logic              llsc_full_i,
  output logic              resp1_valid_o,
  output logic [TAG_W-1:0]  resp1_tag_o,
  output logic              resp1_success_o,
  output logic              resp2_valid_o,
  output logic [TAG_W-1:0]  resp2_tag_o,
  output logic              resp2_success_o,
  output logic              stall_timeout_o
);

  localparam int unsigned TypeW  = $bits(MEM_INST_TYPE);
  localparam int unsigned EntryW = TypeW + 64 + TAG_W;
  localparam int unsigned CntW   = $clog2(Q_DEPTH) + 1;
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  logic [CntW-1:0]   free;
  logic              wr1_en, wr2_en;
  logic [1:0]        rd_cnt;
  logic              e0_valid, e1_valid;
  logic [EntryW-1:0] e0, e1;
  MEM_INST_TYPE      e0_type, e1_type;
  logic [63:0]       e0_addr, e1_addr;
  logic [TAG_W-1:0]  e0_tag, e1_tag;
  logic              issue0, issue1;

  llsc_state_e       state_q, state_d;
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

  logic              resp1_valid_d, resp2_valid_d, resp1_success_d, resp2_success_d;
  logic [TAG_W-1:0]  resp1_tag_d, resp2_tag_d;

  assign req1_ready_o = (free != '0);
  assign req2_ready_o = (free >= CntW'(2));

  assign wr1_en = !flush_i && req1_valid_i && req1_ready_o && is_llsc_inst(req1_type_i);
  assign wr2_en = !flush_i && req2_valid_i && req2_ready_o && is_llsc_inst(req2_type_i);

  llsc_req_fifo #(
    .Depth (Q_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .wr1_en_i    (wr1_en),
    .wr1_data_i  ({req1_type_i, req1_addr_i, req1_tag_i}),
    .wr2_en_i    (wr2_en),
    .wr2_data_i  ({req2_type_i, req2_addr_i, req2_tag_i}),
    .rd_cnt_i    (rd_cnt),
    .rd0_valid_o (e0_valid),
    .rd0_data_o  (e0),
    .rd1_valid_o (e1_valid),
    .rd1_data_o  (e1),
    .free_o      (free)
  );

  assign e0_type = MEM_INST_TYPE'(e0[EntryW-1 -: TypeW]);
  assign e0_addr = e0[TAG_W +: 64];
  assign e0_tag  = e0[TAG_W-1:0];
  assign e1_type = MEM_INST_TYPE'(e1[EntryW-1 -: TypeW]);
  assign e1_addr = e1[TAG_W +: 64];
  assign e1_tag  = e1[TAG_W-1:0];

  always_comb begin
    issue0 = 1'b0;
    issue1 = 1'b0;
    if (!flush_i && e0_valid && !(e0_type == IS_LDL_INST && llsc_full_i)) begin
      issue0 = 1'b1;
      // A second LDL cannot claim a reservation slot when the table is full either.
      issue1 = e1_valid && (e1_addr != e0_addr) &&
               !(e1_type == IS_LDL_INST && (e0_type == IS_LDL_INST || llsc_full_i));
    end
  end

  assign rd_cnt = 2'(issue0) + 2'(issue1);

  assign llsc_inst1_type_o = issue0 ? e0_type : NO_MEM_INST;
  assign llsc_inst1_addr_o = issue0 ? e0_addr : '0;
  assign llsc_inst2_type_o = issue1 ? e1_type : NO_MEM_INST;
  assign llsc_inst2_addr_o = issue1 ? e1_addr : '0;

  always_comb begin
    resp1_valid_d   = issue0;
    resp1_tag_d     = issue0 ? e0_tag : '0;
    resp1_success_d = issue0 && resp_success(e0_type, llsc_inst1_store_success_i);
    resp2_valid_d   = issue1;
    resp2_tag_d     = issue1 ? e1_tag : '0;
    resp2_success_d = issue1 && resp_success(e1_type, llsc_inst2_store_success_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp1_valid_o   <= 1'b0;
      resp1_tag_o     <= '0;
      resp1_success_o <= 1'b0;
      resp2_valid_o   <= 1'b0;
      resp2_tag_o     <= '0;
      resp2_success_o <= 1'b0;
    end else begin
      resp1_valid_o   <= resp1_valid_d;
      resp1_tag_o     <= resp1_tag_d;
      resp1_success_o <= resp1_success_d;
      resp2_valid_o   <= resp2_valid_d;
      resp2_tag_o     <= resp2_tag_d;
      resp2_success_o <= resp2_success_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:   if (e0_valid && e0_type == IS_LDL_INST && llsc_full_i) state_d = StStall;
        StStall: if (!llsc_full_i) state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    if (state_q == StStall && state_d == StStall) begin
      stall_cnt_d = (stall_cnt_q == StallW'(STALL_LIMIT)) ? stall_cnt_q
                                                          : stall_cnt_q + StallW'(1);
    end
    stall_timeout_o = (stall_cnt_q == StallW'(STALL_LIMIT));
  end

endmodule

// File: tb/tb_llsc_arbiter.sv
// Bench for llsc_arbiter: a vector table plus hand-written multi-cycle sequences,
// with a response scoreboard and a one-reservation stand-in for the reservation table.
module tb_llsc_arbiter;
  import llsc_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         req1_valid = 1'b0, req2_valid = 1'b0;
  MEM_INST_TYPE req1_type = NO_MEM_INST, req2_type = NO_MEM_INST;
  logic [63:0]  req1_addr = '0, req2_addr = '0;
  logic [5:0]   req1_tag = '0, req2_tag = '0;
  logic         req1_ready, req2_ready;
  MEM_INST_TYPE inst1_type, inst2_type;
  logic [63:0]  inst1_addr, inst2_addr;
  logic         ss1, ss2;
  logic         llsc_full = 1'b0;
  logic         resp1_valid, resp2_valid, resp1_success, resp2_success;
  logic [5:0]   resp1_tag, resp2_tag;
  logic         stall_to;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [5:0] tag;
    logic       succ;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    MEM_INST_TYPE typ;
    logic [63:0]  addr;
    logic [5:0]   tag;
    MEM_INST_TYPE exp_type;
    logic [63:0]  exp_addr;
    logic         exp_succ;
  } vec_t;
  vec_t vecs[7];

  llsc_arbiter #(
    .Q_DEPTH     (4),
    .TAG_W       (6),
    .STALL_LIMIT (16)
  ) dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_n),
    .flush_i                    (flush),
    .req1_valid_i               (req1_valid),
    .req1_type_i                (req1_type),
    .req1_addr_i                (req1_addr),
    .req1_tag_i                 (req1_tag),
    .req1_ready_o               (req1_ready),
    .req2_valid_i               (req2_valid),
    .req2_type_i                (req2_type),
    .req2_addr_i                (req2_addr),
    .req2_tag_i                 (req2_tag),
    .req2_ready_o               (req2_ready),
    .llsc_inst1_type_o          (inst1_type),
    .llsc_inst1_addr_o          (inst1_addr),
    .llsc_inst1_store_success_i (ss1),
    .llsc_inst2_type_o          (inst2_type),
    .llsc_inst2_addr_o          (inst2_addr),
    .llsc_inst2_store_success_i (ss2),
    .llsc_full_i                (llsc_full),
    .resp1_valid_o              (resp1_valid),
    .resp1_tag_o                (resp1_tag),
    .resp1_success_o            (resp1_success),
    .resp2_valid_o              (resp2_valid),
    .resp2_tag_o                (resp2_tag),
    .resp2_success_o            (resp2_success),
    .stall_timeout_o            (stall_to)
  );

  always #5 clk = ~clk;

  // Single-reservation stand-in: LDL reserves, any store to that address clears.
  logic [64:0] res_q, res_1, res_2;
  function automatic logic [64:0] res_next(input logic [64:0] cur, input MEM_INST_TYPE t,
                                           input logic [63:0] a);
    logic [64:0] n;
    n = cur;
    if (t == IS_LDL_INST) n = {1'b1, a};
    else if ((t == IS_STQ_INST || t == IS_STQ_C_INST) && cur[64] && cur[63:0] == a)
      n = {1'b0, cur[63:0]};
    return n;
  endfunction
  assign res_1 = res_next(res_q, inst1_type, inst1_addr);
  assign res_2 = res_next(res_1, inst2_type, inst2_addr);
  assign ss1   = (inst1_type == IS_STQ_C_INST) && res_q[64] && res_q[63:0] == inst1_addr;
  assign ss2   = (inst2_type == IS_STQ_C_INST) && res_1[64] && res_1[63:0] == inst2_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_resp(input string name, input logic [5:0] tag, input logic succ);
    exp_t e;
    if (exp_q.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s unexpected: got tag %0d, expected no response at %0t", name, tag, $time);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_tag"}, 64'(tag), 64'(e.tag));
      chk({name, "_success"}, 64'(succ), 64'(e.succ));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (resp1_valid) check_resp("resp1", resp1_tag, resp1_success);
      if (resp2_valid) check_resp("resp2", resp2_tag, resp2_success);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req1_valid = 1'b0;
    req2_valid = 1'b0;
  endtask

  task automatic drv1(input MEM_INST_TYPE t, input logic [63:0] a, input logic [5:0] tag,
                      input bit push, input logic succ);
    req1_valid = 1'b1; req1_type = t; req1_addr = a; req1_tag = tag;
    if (push) exp_q.push_back('{tag: tag, succ: succ});
  endtask

  task automatic drv2(input MEM_INST_TYPE t, input logic [63:0] a, input logic [5:0] tag,
                      input bit push, input logic succ);
    req2_valid = 1'b1; req2_type = t; req2_addr = a; req2_tag = tag;
    if (push) exp_q.push_back('{tag: tag, succ: succ});
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req1_ready"}, 64'(req1_ready), 64'd1);
    chk({pfx, "_req2_ready"}, 64'(req2_ready), 64'd1);
    chk({pfx, "_resp1_valid"}, 64'(resp1_valid), 64'd0);
    chk({pfx, "_resp2_valid"}, 64'(resp2_valid), 64'd0);
    chk({pfx, "_resp_tags"}, 64'({resp1_tag, resp2_tag}), 64'd0);
    chk({pfx, "_resp_success"}, 64'({resp1_success, resp2_success}), 64'd0);
    chk({pfx, "_inst1_type"}, 64'(inst1_type), 64'(NO_MEM_INST));
    chk({pfx, "_inst2_type"}, 64'(inst2_type), 64'(NO_MEM_INST));
    chk({pfx, "_inst_addrs"}, inst1_addr | inst2_addr, 64'd0);
    chk({pfx, "_stall_timeout"}, 64'(stall_to), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{IS_LD_INST,    64'h10, 6'd1, NO_MEM_INST,   64'h0,  1'b0};
    vecs[1] = '{IS_LDL_INST,   64'h40, 6'd2, IS_LDL_INST,   64'h40, 1'b0};
    vecs[2] = '{IS_STQ_INST,   64'h80, 6'd5, IS_STQ_INST,   64'h80, 1'b1};
    vecs[3] = '{IS_STQ_C_INST, 64'h40, 6'd6, IS_STQ_C_INST, 64'h40, 1'b1};
    vecs[4] = '{IS_STQ_C_INST, 64'h40, 6'd7, IS_STQ_C_INST, 64'h40, 1'b0};
    vecs[5] = '{IS_ST_INST,    64'h50, 6'd8, NO_MEM_INST,   64'h0,  1'b0};
    vecs[6] = '{NO_MEM_INST,   64'h58, 6'd9, NO_MEM_INST,   64'h0,  1'b0};

    #3;
    chk_reset_outputs("reset");
    tick();
    rst_n = 1'b1;

    // Single requests: dropped types never reach the table.
    foreach (vecs[i]) begin
      tick();
      drv1(vecs[i].typ, vecs[i].addr, vecs[i].tag, vecs[i].exp_type != NO_MEM_INST,
           vecs[i].exp_succ);
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_type", i), 64'(inst1_type), 64'(vecs[i].exp_type));
      chk($sformatf("vec%0d_addr", i), inst1_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_inst2", i), 64'(inst2_type), 64'(NO_MEM_INST));
      tick();
    end

    // Same-address LDL/STQ_C pair serialises; STQ_C succeeds.
    tick();
    drv1(IS_LDL_INST, 64'h100, 6'd3, 1, 1'b0);
    drv2(IS_STQ_C_INST, 64'h100, 6'd4, 1, 1'b1);
    tick(); idle(); #1;
    chk("pair_n1_inst1", 64'(inst1_type), 64'(IS_LDL_INST));
    chk("pair_n1_inst2", 64'(inst2_type), 64'(NO_MEM_INST));
    tick();
    chk("pair_n2_inst1", 64'(inst1_type), 64'(IS_STQ_C_INST));
    chk("pair_n2_addr", inst1_addr, 64'h100);
    tick();
    chk("pair_n3_resp", 64'({resp1_valid, resp1_tag, resp1_success}), 64'({1'b1, 6'd4, 1'b1}));
    tick();

    // LDL, STQ, STQ_C to one address: intervening store kills the reservation.
    tick();
    drv1(IS_LDL_INST, 64'h200, 6'd10, 1, 1'b0);
    drv2(IS_STQ_INST, 64'h200, 6'd11, 1, 1'b1);
    tick(); idle();
    drv1(IS_STQ_C_INST, 64'h200, 6'd12, 1, 1'b0);
    #1;
    chk("ldl_stq_n1", 64'(inst1_type), 64'(IS_LDL_INST));
    tick(); idle(); #1;
    chk("ldl_stq_n2", 64'(inst1_type), 64'(IS_STQ_INST));
    chk("ldl_stq_n2_inst2", 64'(inst2_type), 64'(NO_MEM_INST));
    tick();
    chk("ldl_stq_n3", 64'(inst1_type), 64'(IS_STQ_C_INST));
    tick(); tick();

    // Dual issue on distinct addresses; LDL behind LDL waits.
    drv1(IS_STQ_INST, 64'h500, 6'd13, 1, 1'b1);
    drv2(IS_LDL_INST, 64'h600, 6'd14, 1, 1'b0);
    tick(); idle(); #1;
    chk("dual_inst1", 64'(inst1_type), 64'(IS_STQ_INST));
    chk("dual_inst2", 64'({inst2_type, inst2_addr}), 64'h600 | (64'(IS_LDL_INST) << 64));
    chk("dual_inst2_type", 64'(inst2_type), 64'(IS_LDL_INST));
    tick();
    chk("dual_resp2", 64'({resp2_valid, resp2_tag}), 64'({1'b1, 6'd14}));
    drv1(IS_LDL_INST, 64'h700, 6'd15, 1, 1'b0);
    drv2(IS_LDL_INST, 64'h780, 6'd16, 1, 1'b0);
    tick(); idle(); #1;
    chk("ldl_ldl_n1_inst2", 64'(inst2_type), 64'(NO_MEM_INST));
    tick();
    chk("ldl_ldl_n2_addr", inst1_addr, 64'h780);
    tick(); tick();

    // Stall with head LDL and full table; nothing behind it may overtake.
    llsc_full = 1'b1;
    drv1(IS_LDL_INST, 64'h300, 6'd20, 1, 1'b0);
    drv2(IS_STQ_INST, 64'h310, 6'd21, 1, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      idle();
      #1;
      chk($sformatf("stall_c%0d_noissue", i), 64'(inst1_type), 64'(NO_MEM_INST));
      chk($sformatf("stall_c%0d_timeout", i), 64'(stall_to), 64'(i >= 18));
    end
    tick();
    llsc_full = 1'b0;
    #1;
    chk("stall_release_inst1", 64'(inst1_type), 64'(IS_LDL_INST));
    chk("stall_release_inst2", inst2_addr, 64'h310);
    chk("stall_release_timeout", 64'(stall_to), 64'd1);
    tick();
    chk("stall_after_timeout", 64'(stall_to), 64'd0);
    tick(); tick();

    // Fill to depth, then free one slot.
    llsc_full = 1'b1;
    drv1(IS_LDL_INST, 64'h400, 6'd30, 1, 1'b0);
    drv2(IS_STQ_INST, 64'h400, 6'd31, 1, 1'b1);
    tick(); idle(); #1;
    chk("fill_half_ready2", 64'(req2_ready), 64'd1);
    drv1(IS_STQ_INST, 64'h410, 6'd32, 1, 1'b1);
    drv2(IS_STQ_INST, 64'h418, 6'd33, 1, 1'b1);
    tick(); idle(); #1;
    chk("fill_full_ready", 64'({req1_ready, req2_ready}), 64'd0);
    tick();
    llsc_full = 1'b0;
    #1;
    chk("fill_single_issue", 64'({inst1_type, inst2_type}), 64'({IS_LDL_INST, NO_MEM_INST}));
    tick();
    chk("fill_one_free_ready", 64'({req1_ready, req2_ready}), 64'b10);
    tick(); tick(); tick();

    // Ten fill/drain passes of three entries walk the pointers round the ring.
    for (int p = 0; p < 10; p++) begin
      drv1(IS_LDL_INST, 64'h1000 + 64'(p * 64), 6'(p * 3), 1, 1'b0);
      drv2(IS_STQ_INST, 64'h1008 + 64'(p * 64), 6'(p * 3 + 1), 1, 1'b1);
      tick(); idle();
      drv1(IS_STQ_INST, 64'h1010 + 64'(p * 64), 6'(p * 3 + 2), 1, 1'b1);
      #1;
      chk($sformatf("wrap%0d_inst1", p), inst1_addr, 64'h1000 + 64'(p * 64));
      chk($sformatf("wrap%0d_inst2", p), inst2_addr, 64'h1008 + 64'(p * 64));
      tick(); idle(); #1;
      chk($sformatf("wrap%0d_third", p), inst1_addr, 64'h1010 + 64'(p * 64));
      tick(); tick(); tick();
    end

    // Flush with a pending issue and a new request in the same cycle.
    drv1(IS_STQ_INST, 64'h600, 6'd50, 1, 1'b1);
    tick(); idle();
    flush = 1'b1;
    drv1(IS_LDL_INST, 64'h610, 6'd51, 0, 1'b0);
    exp_q.delete();
    #1;
    chk("flush_no_issue", 64'(inst1_type), 64'(NO_MEM_INST));
    tick();
    flush = 1'b0;
    idle();
    #1;
    chk("flush_no_resp", 64'({resp1_valid, resp2_valid}), 64'd0);
    chk("flush_empty", 64'({req1_ready, req2_ready}), 64'b11);
    chk("flush_no_issue_after", 64'(inst1_type), 64'(NO_MEM_INST));
    tick();
    chk("flush_nothing_queued", 64'(inst1_type), 64'(NO_MEM_INST));

    // Flush out of a timed-out stall returns to RUN with the counter cleared.
    llsc_full = 1'b1;
    drv1(IS_LDL_INST, 64'h680, 6'd52, 0, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      tick();
      idle();
    end
    chk("flush_stall_timeout", 64'(stall_to), 64'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    llsc_full = 1'b0;
    #1;
    chk("flush_stall_cleared", 64'(stall_to), 64'd0);
    chk("flush_stall_empty", 64'(inst1_type), 64'(NO_MEM_INST));
    tick();

    // Reset mid-stall with three entries queued.
    llsc_full = 1'b1;
    drv1(IS_LDL_INST, 64'h700, 6'd60, 0, 1'b0);
    drv2(IS_STQ_INST, 64'h708, 6'd61, 0, 1'b1);
    tick(); idle();
    drv1(IS_STQ_INST, 64'h710, 6'd62, 0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      idle();
    end
    chk("rst_pre_timeout", 64'(stall_to), 64'd1);
    chk("rst_pre_ready", 64'({req1_ready, req2_ready}), 64'b10);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("midrst");
    tick(); tick();
    llsc_full = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d_noissue", i), 64'(inst1_type), 64'(NO_MEM_INST));
      chk($sformatf("post_rst%0d_noresp", i), 64'(resp1_valid), 64'd0);
    end
    drv1(IS_STQ_C_INST, 64'h720, 6'd63, 1, 1'b0);
    tick(); idle(); #1;
    chk("post_rst_new_issue", 64'(inst1_type), 64'(IS_STQ_C_INST));
    tick(); tick(); tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
